// File: rtl/io_uart_fifo_pkg.sv
// Shared definitions for the IO-space UART FIFO peripheral: register offsets,
// STAT/CTRL bit positions, TX FSM encodings and the STAT register layout.
package io_uart_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] OFF_DATA  = 2'd0;
  localparam logic [1:0] OFF_STAT  = 2'd1;
  localparam logic [1:0] OFF_CTRL  = 2'd2;
  localparam logic [1:0] OFF_RXLVL = 2'd3;

  localparam int STAT_TX_FULL     = 0;
  localparam int STAT_TX_EMPTY    = 1;
  localparam int STAT_TX_ACTIVE   = 2;
  localparam int STAT_TX_DROP     = 3;
  localparam int STAT_RX_NONEMPTY = 4;
  localparam int STAT_RX_FULL     = 5;
  localparam int STAT_RX_OVERRUN  = 6;
  localparam int STAT_IRQ         = 7;

  localparam int CTRL_RX_IE    = 0;
  localparam int CTRL_TXE_IE   = 1;
  localparam int CTRL_LOOPBACK = 2;
  localparam int CTRL_FLUSH    = 7;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_ACK   = 2'd2;
  localparam logic [1:0] TX_DONE  = 2'd3;

  // Member order matches the STAT bit layout, MSB first.
  typedef struct packed {
    logic irq;
    logic rx_overrun;
    logic rx_full;
    logic rx_nonempty;
    logic tx_drop;
    logic tx_active;
    logic tx_empty;
    logic tx_full;
  } stat_t;

endpackage

// File: rtl/io_uart_fifo_if.sv
// CPU IO-bus bundle between the light8080 core and the UART FIFO peripheral.
interface io_uart_fifo_if;
  import io_uart_pkg::*;

  logic              cpu_io;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [7:0]        cpu_addr;
  logic [DATA_W-1:0] cpu_dout;
  logic [DATA_W-1:0] io_dout;
  logic              irq;

  modport master (
    output cpu_io, cpu_rd, cpu_wr, cpu_addr, cpu_dout,
    input  io_dout, irq
  );

  modport slave (
    input  cpu_io, cpu_rd, cpu_wr, cpu_addr, cpu_dout,
    output io_dout, irq
  );

endinterface

// File: rtl/io_uart_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO with one-cycle flush; pop on empty is ignored and
// a push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_uart_fifo.sv
// IO-space UART front end: TX/RX FIFOs, CTRL/STAT/RXLVL registers, sticky error
// flags, level irq and the tx_start handshake FSM. Optional: IO_UART_LOOPBACK_EN.
module io_uart_fifo
  import io_uart_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'h80,
  parameter int         TX_DEPTH    = 16,
  parameter int         RX_DEPTH    = 16,
  parameter int         ACK_TIMEOUT = 3
) (
  input  logic              clk,
  input  logic              rstb,
  io_uart_fifo_if.slave     cpu,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_byte,
  input  logic              uart_busy,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_byte
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);

  function automatic logic [7:0] sat_lvl(input logic [RX_CW-1:0] c);
    if (32'(c) > 32'd255) return 8'hFF;
    return 8'(c);
  endfunction

  logic [7:0]        offset;
  logic [1:0]        reg_off;
  logic              addr_hit;
  logic              sel;
  logic              rd_req;
  logic              rd_req_p1;
  logic              rd_rise;
  logic              wr_req;
  logic              wr_data;
  logic              wr_ctrl;
  logic              rd_data_pop;
  logic              rd_stat;
  logic              flush;

  logic              rx_ie;
  logic              txe_ie;
  logic              loopback;
  logic              tx_drop;
  logic              rx_overrun;
  logic              irq_p1;
  logic [DATA_W-1:0] io_dout_p1;
  logic [DATA_W-1:0] rd_val;

  logic [1:0]        tx_state;
  logic [TW-1:0]     ack_cnt;
  logic              lb_active;
  logic              launch;

  logic [DATA_W-1:0] tx_head;
  logic              tx_full;
  logic              tx_empty;
  logic [TX_CW-1:0]  tx_count;
  logic [DATA_W-1:0] rx_head;
  logic              rx_full;
  logic              rx_empty;
  logic [RX_CW-1:0]  rx_count;
  logic              rx_push;
  logic [DATA_W-1:0] rx_din;
  logic              tx_drop_set;
  logic              rx_ovr_set;
  logic              tx_idle;
  stat_t             stat;
  logic              unused_bits;

  // Window decode works for any BASE_ADDR, aligned or not.
  assign offset   = cpu.cpu_addr - BASE_ADDR;
  assign addr_hit = (offset[7:2] == 6'd0);
  assign reg_off  = offset[1:0];
  assign sel      = cpu.cpu_io & addr_hit;
  assign rd_req   = sel & cpu.cpu_rd;
  assign rd_rise  = rd_req & ~rd_req_p1;
  assign wr_req   = sel & cpu.cpu_wr;

  assign wr_data     = wr_req & (reg_off == OFF_DATA);
  assign wr_ctrl     = wr_req & (reg_off == OFF_CTRL);
  assign rd_data_pop = rd_rise & (reg_off == OFF_DATA);
  assign rd_stat     = rd_rise & (reg_off == OFF_STAT);
  assign flush       = wr_ctrl & cpu.cpu_dout[CTRL_FLUSH];

  assign tx_idle = (tx_state == TX_IDLE);
  assign launch  = tx_idle & ~tx_empty & ~uart_busy & ~flush;

  // In loopback the launched byte replaces the uart as the RX source.
  assign rx_push = loopback ? launch : rx_valid;
  assign rx_din  = loopback ? tx_head : rx_byte;

  assign tx_drop_set = wr_data & tx_full & ~launch & ~flush;
  assign rx_ovr_set  = rx_push & rx_full & ~rd_data_pop & ~flush;

  assign unused_bits = ^{cpu.cpu_dout[6:3], cpu.cpu_dout[CTRL_LOOPBACK]};

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (wr_data),
    .pop   (launch),
    .flush (flush),
    .din   (cpu.cpu_dout),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (rx_push),
    .pop   (rd_data_pop),
    .flush (flush),
    .din   (rx_din),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_comb begin
    stat.tx_full     = tx_full;
    stat.tx_empty    = tx_empty;
    stat.tx_active   = ~tx_idle | uart_busy;
    stat.tx_drop     = tx_drop;
    stat.rx_nonempty = ~rx_empty;
    stat.rx_full     = rx_full;
    stat.rx_overrun  = rx_overrun;
    stat.irq         = irq_p1;
  end

  always_comb begin
    rd_val = '0;
    case (reg_off)
      OFF_DATA:  rd_val = rx_empty ? '0 : rx_head;
      OFF_STAT:  rd_val = stat;
      OFF_CTRL:  rd_val = {5'd0, loopback, txe_ie, rx_ie};
      OFF_RXLVL: rd_val = sat_lvl(rx_count);
      default:   rd_val = '0;
    endcase
  end

  // Bus stage: registered read data, read-edge tracking, irq.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      io_dout_p1 <= '0;
      rd_req_p1  <= 1'b0;
      irq_p1     <= 1'b0;
    end else begin
      if (cpu.cpu_io) io_dout_p1 <= addr_hit ? rd_val : '0;
      rd_req_p1 <= rd_req;
      irq_p1    <= (rx_ie & (~rx_empty | rx_overrun)) |
                   (txe_ie & tx_empty & tx_idle & ~uart_busy);
    end
  end

  assign cpu.io_dout = io_dout_p1;
  assign cpu.irq     = irq_p1;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_ie      <= 1'b0;
      txe_ie     <= 1'b0;
      tx_drop    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        rx_ie  <= cpu.cpu_dout[CTRL_RX_IE];
        txe_ie <= cpu.cpu_dout[CTRL_TXE_IE];
      end
      // A new event in the clearing cycle was not seen by the reader, so it wins.
      tx_drop    <= (tx_drop    & ~rd_stat) | tx_drop_set;
      rx_overrun <= (rx_overrun & ~rd_stat) | rx_ovr_set;
    end
  end

`ifdef IO_UART_LOOPBACK_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)        loopback <= 1'b0;
    else if (wr_ctrl) loopback <= cpu.cpu_dout[CTRL_LOOPBACK];
  end
`else
  assign loopback = 1'b0;
`endif

  // TX stage: tx_start/tx_byte are registered on entry to START.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tx_state  <= TX_IDLE;
      ack_cnt   <= '0;
      lb_active <= 1'b0;
      tx_start  <= 1'b0;
      tx_byte   <= '0;
    end else begin
      tx_start <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (launch) begin
            tx_state  <= TX_START;
            lb_active <= loopback;
            if (!loopback) begin
              tx_start <= 1'b1;
              tx_byte  <= tx_head;
            end
          end
        end
        TX_START: begin
          ack_cnt  <= '0;
          tx_state <= lb_active ? TX_IDLE : TX_ACK;
        end
        TX_ACK: begin
          if (uart_busy)                tx_state <= TX_DONE;
          else if (ack_cnt == ACK_LAST) tx_state <= TX_IDLE;
          else                          ack_cnt  <= ack_cnt + 1'b1;
        end
        TX_DONE: begin
          if (!uart_busy) tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_fifo.sv
// Randomized bench for io_uart_fifo against a queue-based model of the register
// map, FIFOs, sticky flags and irq; a simple uart model drives uart_busy.
module tb_io_uart_fifo;

  localparam int         TXD  = 4;
  localparam int         RXD  = 16;
  localparam logic [7:0] BASE = 8'h80;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       uart_busy;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  always #5 clk = ~clk;

  io_uart_fifo_if bus();

  io_uart_fifo #(
    .BASE_ADDR   (BASE),
    .TX_DEPTH    (TXD),
    .RX_DEPTH    (RXD),
    .ACK_TIMEOUT (3)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .cpu       (bus),
    .tx_start  (tx_start),
    .tx_byte   (tx_byte),
    .uart_busy (uart_busy),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_len = 10;
  int   busy_cnt = 0;
  logic busy_force = 1'b0;
  int   n_tx_pulses = 0;
  logic tx_start_prev = 1'b0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_mdl[$];
  logic       m_tx_drop = 1'b0;
  logic       m_rx_ovr = 1'b0;
  logic       m_rx_ie = 1'b0;
  logic       m_txe_ie = 1'b0;
  logic       m_lb = 1'b0;

  assign uart_busy = busy_force | (busy_cnt != 0);

  always @(posedge clk) begin
    if (tx_start && busy_cnt == 0) busy_cnt <= busy_len;
    else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_start) begin
      n_tx_pulses <= n_tx_pulses + 1;
      check_val("tx_busy_low", uart_busy, 1'b0);
      check_val("tx_single_cycle", tx_start_prev, 1'b0);
      check_val("tx_pending", tx_exp.size() != 0, 1'b1);
      if (tx_exp.size() != 0) check_val("tx_byte", tx_byte, tx_exp.pop_front());
    end
    tx_start_prev <= tx_start;
  end

  function automatic logic irq_model();
    return (m_rx_ie && (rx_mdl.size() != 0 || m_rx_ovr)) ||
           (m_txe_ie && tx_exp.size() == 0 && !uart_busy);
  endfunction

  // Valid only while the TX side is quiescent (nothing launching).
  function automatic logic [7:0] stat_model();
    logic [7:0] s;
    s[0] = (tx_exp.size() == TXD);
    s[1] = (tx_exp.size() == 0);
    s[2] = uart_busy;
    s[3] = m_tx_drop;
    s[4] = (rx_mdl.size() != 0);
    s[5] = (rx_mdl.size() == RXD);
    s[6] = m_rx_ovr;
    s[7] = irq_model();
    return s;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cpu_io = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = a; bus.cpu_dout = d;
    if (a == BASE) begin
      if (tx_exp.size() >= TXD) m_tx_drop = 1'b1;
      else tx_exp.push_back(d);
    end else if (a == BASE + 8'd2) begin
      m_rx_ie  = d[0];
      m_txe_ie = d[1];
`ifdef IO_UART_LOOPBACK_EN
      m_lb     = d[2];
`endif
      if (d[7]) begin
        tx_exp.delete();
        rx_mdl.delete();
      end
    end
    @(negedge clk);
    bus.cpu_io = 1'b0; bus.cpu_wr = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d, input int hold);
    @(negedge clk);
    bus.cpu_io = 1'b1; bus.cpu_rd = 1'b1; bus.cpu_addr = a;
    @(negedge clk);
    d = bus.io_dout;
    repeat (hold - 1) @(negedge clk);
    bus.cpu_io = 1'b0; bus.cpu_rd = 1'b0;
  endtask

  task automatic rx_inject(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_byte = b;
    if (rx_mdl.size() >= RXD) m_rx_ovr = 1'b1;
    else rx_mdl.push_back(b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic rd_data_chk(input string tag, input int hold);
    logic [7:0] d;
    logic [7:0] exp;
    exp = (rx_mdl.size() != 0) ? rx_mdl.pop_front() : 8'h00;
    io_read(BASE, d, hold);
    check_val(tag, d, exp);
  endtask

  task automatic rd_stat_chk(input string tag);
    logic [7:0] d;
    logic [7:0] exp;
    exp = stat_model();
    io_read(BASE + 8'd1, d, 1);
    check_val(tag, d, exp);
    m_tx_drop = 1'b0;
    m_rx_ovr  = 1'b0;
  endtask

  task automatic rd_ctrl_chk(input string tag);
    logic [7:0] d;
    io_read(BASE + 8'd2, d, 1);
    check_val(tag, d, {5'd0, m_lb, m_txe_ie, m_rx_ie});
  endtask

  task automatic rd_lvl_chk(input string tag);
    logic [7:0] d;
    io_read(BASE + 8'd3, d, 1);
    check_val(tag, d, (rx_mdl.size() > 255) ? 255 : rx_mdl.size());
  endtask

  task automatic wait_tx_drain(input string tag, input int bound);
    int stable = 0;
    for (int k = 0; k < bound && stable < 3; k++) begin
      @(negedge clk);
      if (tx_exp.size() == 0 && !uart_busy) stable++;
      else stable = 0;
    end
    check_val(tag, stable >= 3, 1'b1);
    cyc(4);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bus.cpu_io = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    bus.cpu_addr = 8'h00; bus.cpu_dout = 8'h00;
    cyc(3);
    check_val("rst_io_dout", bus.io_dout, 8'h00);
    check_val("rst_irq", bus.irq, 1'b0);
    check_val("rst_tx_start", tx_start, 1'b0);
    check_val("rst_tx_byte", tx_byte, 8'h00);
    rstb = 1'b1;
    cyc(2);
    rd_stat_chk("rst_stat");
    rd_ctrl_chk("rst_ctrl");
    rd_lvl_chk("rst_rxlvl");

    // Three bytes through a 10-cycle uart.
    busy_len = 10;
    p0 = n_tx_pulses;
    io_write(BASE, 8'h41);
    io_write(BASE, 8'h42);
    io_write(BASE, 8'h43);
    wait_tx_drain("tx3_drain", 300);
    check_val("tx3_pulses", n_tx_pulses - p0, 3);
    rd_stat_chk("tx3_stat");

    // TX overflow while the uart is held busy.
    busy_force = 1'b1;
    cyc(2);
    for (int i = 0; i < 6; i++) io_write(BASE, 8'($urandom));
    rd_stat_chk("txfull_stat");
    rd_stat_chk("txfull_stat_clr");
    busy_force = 1'b0;
    wait_tx_drain("txfull_drain", 400);
    rd_stat_chk("txfull_after");

    // RX overrun and ordered drain.
    for (int i = 0; i < 17; i++) rx_inject(8'(i));
    rd_lvl_chk("rx_lvl_full");
    rd_stat_chk("rx_ovr_stat");
    for (int i = 0; i < 16; i++) rd_data_chk("rx_pop", 1);
    rd_data_chk("rx_empty_pop", 1);
    rx_inject(8'($urandom));
    rx_inject(8'($urandom));
    rd_data_chk("rx_hold3", 3);
    rd_lvl_chk("rx_lvl_hold3");
    rd_data_chk("rx_after_hold", 1);
    rd_stat_chk("rx_stat_clean");

    // Interrupts.
    io_write(BASE + 8'd2, 8'h01);
    cyc(2);
    check_val("irq_rx_idle", bus.irq, irq_model());
    rx_inject(8'($urandom));
    cyc(1);
    check_val("irq_rx_set", bus.irq, irq_model());
    rd_data_chk("irq_rx_pop", 1);
    cyc(2);
    check_val("irq_rx_clr", bus.irq, irq_model());
    io_write(BASE + 8'd2, 8'h02);
    cyc(2);
    check_val("irq_txe", bus.irq, irq_model());
    rd_ctrl_chk("ctrl_txe");
    io_write(BASE + 8'd2, 8'h00);
    cyc(2);
    check_val("irq_off", bus.irq, irq_model());

    // Flush in the middle of a transmission.
    busy_len = 20;
    rx_inject(8'($urandom));
    rx_inject(8'($urandom));
    p0 = n_tx_pulses;
    for (int i = 0; i < 5; i++) io_write(BASE, 8'($urandom));
    io_write(BASE + 8'd2, 8'h80);
    wait_tx_drain("flush_drain", 400);
    cyc(30);
    check_val("flush_pulses", n_tx_pulses - p0, 1);
    rd_lvl_chk("flush_rxlvl");
    rd_stat_chk("flush_stat");
    rd_ctrl_chk("flush_ctrl");

`ifdef IO_UART_LOOPBACK_EN
    io_write(BASE + 8'd2, 8'h04);
    p0 = n_tx_pulses;
    io_write(BASE, 8'h5A);
    void'(tx_exp.pop_back());
    rx_mdl.push_back(8'h5A);
    cyc(6);
    rd_data_chk("lb_data", 1);
    check_val("lb_no_tx", n_tx_pulses - p0, 0);
    io_write(BASE + 8'd2, 8'h00);
`else
    io_write(BASE + 8'd2, 8'h04);
    rd_ctrl_chk("lb_disabled");
    io_write(BASE + 8'd2, 8'h00);
`endif

    // Random mixed rounds.
    for (int r = 0; r < 6; r++) begin
      int k;
      int j;
      busy_len = $urandom_range(3, 12);
      k = $urandom_range(1, 3);
      j = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) io_write(BASE, 8'($urandom));
      for (int i = 0; i < j; i++) rx_inject(8'($urandom));
      wait_tx_drain("rnd_drain", 300);
      rd_lvl_chk("rnd_rxlvl");
      while (rx_mdl.size() != 0) rd_data_chk("rnd_pop", 1);
      rd_stat_chk("rnd_stat");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
